// File: rtl/vigna_bus_pkg.sv
// Shared types for the vigna bus RAM: FSM state encodings and port-select constants.
package vigna_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/vigna_bus_ram_if.sv
// Instruction and data valid/ready bus bundle between the vigna core (master) and the RAM (slave).
interface vigna_bus_ram_if;

  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;

  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_addr;
  logic [31:0] d_rdata;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;

  modport master (
    output i_valid, i_addr,
    input  i_ready, i_rdata,
    output d_valid, d_addr, d_wdata, d_wstrb,
    input  d_ready, d_rdata
  );

  modport slave (
    input  i_valid, i_addr,
    output i_ready, i_rdata,
    input  d_valid, d_addr, d_wdata, d_wstrb,
    output d_ready, d_rdata
  );

endinterface

// File: rtl/vigna_ram_array.sv
// Single-port word array with synchronous read and four byte-lane write enables.
module vigna_ram_array #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // The read register doubles as the staging register; it only changes on read accesses.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int n = 0; n < 4; n++) begin
        if (we[n]) mem[addr][8*n +: 8] <= wdata[8*n +: 8];
      end
      if (we == 4'b0000) rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vigna_bus_ram.sv
// Dual-bus RAM responder for the vigna core with round-robin arbitration.
// Optional wait states are compiled in with the VIGNA_BUS_RAM_WAIT_EN macro.
module vigna_bus_ram
  import vigna_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 0
) (
  input logic            clk,
  input logic            resetn,
  vigna_bus_ram_if.slave bus
);

  state_e state_q, state_d;
  logic   port_q, port_d;
  logic   write_q, write_d;
  logic   last_q, last_d;
  logic   i_ready_q, i_ready_d;
  logic   d_ready_q, d_ready_d;
  logic [31:0] i_hold_q, i_hold_d;
  logic [31:0] d_hold_q, d_hold_d;

`ifdef VIGNA_BUS_RAM_WAIT_EN
  localparam int CNT_W = ($clog2(WAIT_CYCLES + 1) > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = (WAIT_CYCLES != 0);
`endif

  logic                  grant;
  logic                  grant_port;
  logic                  grant_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_we;
  logic [31:0]           rd_word;

  // On a tie the port that was not served last wins; a lone requester is served directly.
  assign grant       = (state_q == IDLE) && (bus.i_valid || bus.d_valid);
  assign grant_port  = (bus.i_valid && bus.d_valid) ? ((last_q == PORT_I) ? PORT_D : PORT_I)
                                                    : (bus.d_valid ? PORT_D : PORT_I);
  assign grant_write = (grant_port == PORT_D) && (bus.d_wstrb != 4'b0000);
  assign mem_addr    = (grant_port == PORT_D) ? bus.d_addr[ADDR_WIDTH+1:2]
                                              : bus.i_addr[ADDR_WIDTH+1:2];
  assign mem_we      = (grant && grant_port == PORT_D) ? bus.d_wstrb : 4'b0000;

  vigna_ram_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .en    (grant),
    .addr  (mem_addr),
    .we    (mem_we),
    .wdata (bus.d_wdata),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      port_q    <= PORT_I;
      write_q   <= 1'b0;
      last_q    <= PORT_I;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_hold_q  <= '0;
      d_hold_q  <= '0;
`ifdef VIGNA_BUS_RAM_WAIT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      write_q   <= write_d;
      last_q    <= last_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      i_hold_q  <= i_hold_d;
      d_hold_q  <= d_hold_d;
`ifdef VIGNA_BUS_RAM_WAIT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    write_d = write_q;
    last_d  = last_q;
`ifdef VIGNA_BUS_RAM_WAIT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          port_d  = grant_port;
          write_d = grant_write;
          last_d  = grant_port;
`ifdef VIGNA_BUS_RAM_WAIT_EN
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
`else
          state_d = RESP;
`endif
        end
      end
`ifdef VIGNA_BUS_RAM_WAIT_EN
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = RESP;
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is registered off the next state so it is high exactly for the RESP cycle.
  always_comb begin
    i_ready_d = (state_d == RESP) && (port_d == PORT_I);
    d_ready_d = (state_d == RESP) && (port_d == PORT_D);
    i_hold_d  = i_ready_q ? rd_word : i_hold_q;
    d_hold_d  = (d_ready_q && !write_q) ? rd_word : d_hold_q;
  end

  assign bus.i_ready = i_ready_q;
  assign bus.d_ready = d_ready_q;
  assign bus.i_rdata = i_ready_q ? rd_word : i_hold_q;
  assign bus.d_rdata = (d_ready_q && !write_q) ? rd_word : d_hold_q;

  logic unused_addr;
  assign unused_addr = ^{bus.i_addr[1:0], bus.i_addr[31:ADDR_WIDTH+2],
                         bus.d_addr[1:0], bus.d_addr[31:ADDR_WIDTH+2]};

endmodule

// File: tb/tb_vigna_bus_ram.sv
// Directed self-checking bench for vigna_bus_ram; expected wait states follow VIGNA_BUS_RAM_WAIT_EN.
module tb_vigna_bus_ram;

`ifdef VIGNA_BUS_RAM_WAIT_EN
  localparam int W = 3;
`else
  localparam int W = 0;
`endif

  logic clk = 1'b0;
  logic resetn;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  vigna_bus_ram_if bus ();

  vigna_bus_ram #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer on a single port; returns data seen in the ready cycle and the latency in cycles.
  task automatic access(input logic is_d, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rdata, output int lat);
    logic rdy;
    @(negedge clk);
    if (is_d) begin
      bus.d_valid = 1'b1; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_wstrb = wstrb;
    end else begin
      bus.i_valid = 1'b1; bus.i_addr = addr;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      rdy = is_d ? bus.d_ready : bus.i_ready;
    end while (rdy !== 1'b1 && lat < 40);
    rdata = is_d ? bus.d_rdata : bus.i_rdata;
    @(negedge clk);
    bus.d_valid = 1'b0; bus.i_valid = 1'b0; bus.d_wstrb = 4'b0000;
    check_output(is_d ? "d_pulse" : "i_pulse", {31'b0, is_d ? bus.d_ready : bus.i_ready}, 32'd0);
  endtask

  // Both ports raise valid together; records the cycle each ready shows up.
  task automatic tie(output int di, output int ii, output logic [31:0] dv, output logic [31:0] iv);
    int n;
    @(negedge clk);
    bus.d_valid = 1'b1; bus.d_addr = 32'h10; bus.d_wstrb = 4'b0000;
    bus.i_valid = 1'b1; bus.i_addr = 32'h0;
    di = 0; ii = 0; n = 0; dv = '0; iv = '0;
    while ((di == 0 || ii == 0) && n < 60) begin
      @(negedge clk);
      n++;
      if (di != 0) bus.d_valid = 1'b0;
      if (ii != 0) bus.i_valid = 1'b0;
      if (bus.d_ready === 1'b1 && di == 0) begin di = n; dv = bus.d_rdata; end
      if (bus.i_ready === 1'b1 && ii == 0) begin ii = n; iv = bus.i_rdata; end
    end
    @(negedge clk);
    bus.d_valid = 1'b0; bus.i_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, dv, iv;
    int lat, di, ii;

    bus.i_valid = 1'b0; bus.i_addr = '0;
    bus.d_valid = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = 4'b0000;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_i_ready", {31'b0, bus.i_ready}, 32'd0);
    check_output("rst_d_ready", {31'b0, bus.d_ready}, 32'd0);
    check_output("rst_i_rdata", bus.i_rdata, 32'd0);
    check_output("rst_d_rdata", bus.d_rdata, 32'd0);
    resetn = 1'b1;

    access(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, lat);
    check_output("store_lat", lat, 1 + W);
    access(1'b1, 32'h10, 32'h0, 4'b0000, rd, lat);
    check_output("load_lat", lat, 1 + W);
    check_output("load_word", rd, 32'hDEADBEEF);

    access(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, lat);
    access(1'b1, 32'h10, 32'h0, 4'b0000, rd, lat);
    check_output("lane0", rd, 32'hDEADBEAA);
    access(1'b1, 32'h10, 32'h00005500, 4'b0010, rd, lat);
    access(1'b1, 32'h10, 32'h0, 4'b0000, rd, lat);
    check_output("lane1", rd, 32'hDEAD55AA);

    access(1'b1, 32'h0, 32'h00000013, 4'b1111, rd, lat);
    check_output("store_keeps_rdata", rd, 32'hDEAD55AA);

    access(1'b0, 32'h4010, 32'h0, 4'b0000, rd, lat);
    check_output("fetch_lat", lat, 1 + W);
    check_output("alias_4010", rd, 32'hDEAD55AA);
    check_output("i_hold", bus.i_rdata, 32'hDEAD55AA);
    access(1'b0, 32'h13, 32'h0, 4'b0000, rd, lat);
    check_output("low_bits_ignored", rd, 32'hDEAD55AA);

    // Reset in the middle of a response cycle.
    @(negedge clk);
    bus.d_valid = 1'b1; bus.d_addr = 32'h0; bus.d_wstrb = 4'b0000;
    lat = 0;
    do begin @(negedge clk); lat++; end while (bus.d_ready !== 1'b1 && lat < 40);
    check_output("pre_rst_rdata", bus.d_rdata, 32'h00000013);
    resetn = 1'b0;
    #1;
    check_output("midrst_d_ready", {31'b0, bus.d_ready}, 32'd0);
    check_output("midrst_d_rdata", bus.d_rdata, 32'd0);
    check_output("midrst_i_rdata", bus.i_rdata, 32'd0);
    bus.d_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    tie(di, ii, dv, iv);
    check_output("tie1_d_cycle", di, 1 + W);
    check_output("tie1_i_cycle", ii, 3 + 2 * W);
    check_output("tie1_d_data", dv, 32'hDEAD55AA);
    check_output("tie1_i_data", iv, 32'h00000013);

    access(1'b1, 32'h10, 32'h0, 4'b0000, rd, lat);
    tie(di, ii, dv, iv);
    check_output("tie2_i_cycle", ii, 1 + W);
    check_output("tie2_d_cycle", di, 3 + 2 * W);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
